vram_axi_writer: RTL and testbench

- AXI4-Lite slave that owns the 601-word text-mode VRAM register file and drives it, whole, to the colour mapper.
- Words 0..599 hold glyph words: 4 glyphs per word, each glyph {inv, code[6:0]}, 20 words per 16-pixel row.
- Word 600 holds the palette: fg R/G/B in [24:13], bg R/G/B in [12:1].
- Host (MicroBlaze) writes and reads words over AXI; the colour mapper reads them combinationally.

---
 rtl/vram_axi_writer_if.sv | 33 +++
 rtl/vram_axi_writer.sv | 148 ++++++++++++++
 tb/tb_vram_axi_writer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_axi_writer_if.sv
// AXI4-Lite bus bundle for the text-mode VRAM register file.
// The slave modport is the VRAM side; the master modport is the host side.
interface vram_axi_writer_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/vram_axi_writer.sv
// AXI4-Lite slave owning the text-mode VRAM (glyph words plus palette word), exported whole.
// Optional macro VRAM_CLEAR_EN adds a clear engine triggered by palette-word bit 31.
module vram_axi_writer #(
  parameter int ADDR_W    = 12,
  parameter int NUM_WORDS = 601
) (
  input  logic                  Clk,
  input  logic                  Reset,
  vram_axi_writer_if.slave      axi,
  output logic [31:0]           vram [NUM_WORDS]
);

  localparam int                IDX_W    = ADDR_W - 2;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  logic [31:0]      vram_q [NUM_WORDS];
  logic             aw_full_q, w_full_q, bvalid_q, rvalid_q;
  logic [IDX_W-1:0] aw_idx_q;
  logic [31:0]      w_data_q, rdata_q;
  logic [3:0]       w_strb_q;
  logic [1:0]       bresp_q, rresp_q;

  logic             busy, commit, aw_in_range;
  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [IDX_W-1:0] ar_idx;
  logic             unused_addr_bits;

`ifdef VRAM_CLEAR_EN
  localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(NUM_WORDS - 2);
  logic             clr_busy_q;
  logic [IDX_W-1:0] clr_idx_q;
  logic             clr_start;

  assign busy      = clr_busy_q;
  assign clr_start = commit && (aw_idx_q == LAST_IDX) && w_strb_q[3] && w_data_q[31];
`else
  assign busy = 1'b0;
`endif

  // A held write (address and data latched) blocks both channels until its B handshake.
  assign axi.AWREADY = !aw_full_q && !busy;
  assign axi.WREADY  = !w_full_q && !busy;
  assign axi.BVALID  = bvalid_q;
  assign axi.BRESP   = bresp_q;
  assign axi.ARREADY = !rvalid_q;
  assign axi.RVALID  = rvalid_q;
  assign axi.RDATA   = rdata_q;
  assign axi.RRESP   = rresp_q;

  assign aw_hs       = axi.AWVALID && axi.AWREADY;
  assign w_hs        = axi.WVALID && axi.WREADY;
  assign b_hs        = bvalid_q && axi.BREADY;
  assign ar_hs       = axi.ARVALID && axi.ARREADY;
  assign r_hs        = rvalid_q && axi.RREADY;
  assign commit      = aw_full_q && w_full_q && !bvalid_q;
  assign aw_in_range = (aw_idx_q <= LAST_IDX);
  assign ar_idx      = axi.ARADDR[ADDR_W-1:2];

  assign unused_addr_bits = ^{axi.AWADDR[1:0], axi.ARADDR[1:0]};
  assign vram             = vram_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= axi.AWADDR[ADDR_W-1:2];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= axi.WDATA;
        w_strb_q <= axi.WSTRB;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      if (b_hs) begin
        bvalid_q  <= 1'b0;
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end
    end
  end

  // NOTE: the VRAM is reset word by word because the display must come up blank; this keeps it in flops.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_WORDS; i++) vram_q[i] <= '0;
`ifdef VRAM_CLEAR_EN
      clr_busy_q <= 1'b0;
      clr_idx_q  <= '0;
`endif
    end else begin
      if (commit && aw_in_range) begin
        for (int b = 0; b < 4; b++) begin
          if (w_strb_q[b]) vram_q[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end
`ifdef VRAM_CLEAR_EN
      // The triggering write leaves bit 31 set, which doubles as the busy flag the host reads.
      if (clr_start) begin
        clr_busy_q <= 1'b1;
        clr_idx_q  <= '0;
      end else if (clr_busy_q) begin
        vram_q[clr_idx_q] <= '0;
        if (clr_idx_q == CLR_LAST) begin
          vram_q[NUM_WORDS-1][31] <= 1'b0;
          clr_busy_q              <= 1'b0;
        end else begin
          clr_idx_q <= clr_idx_q + IDX_W'(1);
        end
      end
`endif
    end
  end

  // Reads sample on the AR handshake edge, so a same-edge write returns the old word.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      if (ar_idx <= LAST_IDX) begin
        rdata_q <= vram_q[ar_idx];
        rresp_q <= RESP_OKAY;
      end else begin
        rdata_q <= '0;
        rresp_q <= RESP_SLVERR;
      end
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_axi_writer.sv
// Scoreboard bench for vram_axi_writer: stimulus queues expected B/R responses, a monitor checks them.
// Build with +define+VRAM_CLEAR_EN to exercise the clear engine.
module tb_vram_axi_writer;

  logic        clk;
  logic        rst;
  logic [31:0] vram_w [601];

  vram_axi_writer_if #(.ADDR_W(12)) bus ();

  vram_axi_writer #(.ADDR_W(12), .NUM_WORDS(601)) dut (
    .Clk   (clk),
    .Reset (rst),
    .axi   (bus),
    .vram  (vram_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired, got no response, expected one", name);
  endtask

  // Monitor: compares each B and R handshake against the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.BVALID && bus.BREADY) begin
        if (exp_b.size() == 0) check("b_unexpected", 64'(bus.BRESP) | 64'h100, 64'h0);
        else check("bresp", 64'(bus.BRESP), 64'(exp_b.pop_front()));
      end
      if (bus.RVALID && bus.RREADY) begin
        if (exp_r.size() == 0) check("r_unexpected", {30'h1, bus.RRESP, bus.RDATA}, 64'h0);
        else check("rresp_rdata", 64'({bus.RRESP, bus.RDATA}), 64'(exp_r.pop_front()));
      end
    end
  end

  task automatic issue_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_delay, input int w_delay, input int budget, output int cycles);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_hs, w_hs;
    cycles = 0;
    while (!(aw_done && w_done)) begin
      if (!aw_done && cycles >= aw_delay) begin
        bus.AWADDR  = addr;
        bus.AWVALID = 1'b1;
      end
      if (!w_done && cycles >= w_delay) begin
        bus.WDATA  = data;
        bus.WSTRB  = strb;
        bus.WVALID = 1'b1;
      end
      @(negedge clk);
      aw_hs = bus.AWVALID && bus.AWREADY;
      w_hs  = bus.WVALID && bus.WREADY;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1'b1; bus.AWVALID = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; bus.WVALID  = 1'b0; end
      cycles++;
      if (cycles > budget) begin
        fail("write_handshake_timeout");
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        break;
      end
    end
  endtask

  task automatic issue_read(input logic [11:0] addr);
    bit hs = 1'b0;
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    for (int i = 0; i < 1000 && !hs; i++) begin
      @(negedge clk);
      hs = bus.ARVALID && bus.ARREADY;
      @(posedge clk); #1;
    end
    bus.ARVALID = 1'b0;
    if (!hs) fail("read_handshake_timeout");
  endtask

  // Waits until the monitor has consumed every queued response, then finishes that handshake edge.
  task automatic drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk); #2;
      done = (exp_b.size() == 0) && (exp_r.size() == 0);
    end
    @(posedge clk); #1;
    if (!done) fail("response_drain_timeout");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int bad;
    rst = 1'b1;
    bus.AWADDR = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0;  bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1;
    bus.ARADDR = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bvalid",  64'(bus.BVALID),  64'd0);
    check("rst_rvalid",  64'(bus.RVALID),  64'd0);
    check("rst_awready", 64'(bus.AWREADY), 64'd1);
    check("rst_wready",  64'(bus.WREADY),  64'd1);
    check("rst_arready", 64'(bus.ARREADY), 64'd1);
    check("rst_rdata",   64'(bus.RDATA),   64'd0);
    check("rst_bresp",   64'(bus.BRESP),   64'd0);
    check("rst_rresp",   64'(bus.RRESP),   64'd0);
    check("rst_vram0",   64'(vram_w[0]),   64'd0);
    check("rst_vram600", 64'(vram_w[600]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reads after reset
    exp_r.push_back({2'b00, 32'h0});
    issue_read(12'h000);
    drain(20);
    exp_r.push_back({2'b00, 32'h0});
    issue_read(12'h960);
    drain(20);

    // AW and W in the same cycle
    exp_b.push_back(2'b00);
    issue_write(12'h004, 32'h4142_4344, 4'hF, 0, 0, 20, cyc);
    @(negedge clk);
    check("b_not_before_commit", 64'(bus.BVALID), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_after_commit", 64'(bus.BVALID), 64'd1);
    drain(20);
    check("vram1_full_write", 64'(vram_w[1]), 64'h4142_4344);
    exp_r.push_back({2'b00, 32'h4142_4344});
    issue_read(12'h004);
    drain(20);

    // W one cycle before AW, strobed, with BREADY held low
    bus.BREADY = 1'b0;
    exp_b.push_back(2'b00);
    issue_write(12'h008, 32'hFFFF_FFFF, 4'b0101, 1, 0, 20, cyc);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b_hold_bvalid",  64'(bus.BVALID),  64'd1);
      check("b_hold_bresp",   64'(bus.BRESP),   64'd0);
      check("b_hold_awready", 64'(bus.AWREADY), 64'd0);
      check("b_hold_wready",  64'(bus.WREADY),  64'd0);
      @(posedge clk); #1;
    end
    bus.BREADY = 1'b1;
    drain(20);
    @(negedge clk);
    check("after_b_awready", 64'(bus.AWREADY), 64'd1);
    check("after_b_wready",  64'(bus.WREADY),  64'd1);
    check("vram2_strobed",   64'(vram_w[2]),   64'h00FF_00FF);
    @(posedge clk); #1;

    // Out-of-range index 601
    exp_b.push_back(2'b10);
    issue_write(12'h964, 32'hCAFE_F00D, 4'hF, 0, 0, 20, cyc);
    drain(20);
    check("oor_palette_untouched", 64'(vram_w[600]), 64'd0);
    check("oor_vram1_untouched",   64'(vram_w[1]),   64'h4142_4344);
    exp_r.push_back({2'b10, 32'h0});
    issue_read(12'h964);
    drain(20);

    // Read with RREADY low for 2 cycles
    bus.RREADY = 1'b0;
    exp_r.push_back({2'b00, 32'h4142_4344});
    issue_read(12'h004);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("r_hold_rvalid",  64'(bus.RVALID),  64'd1);
      check("r_hold_rdata",   64'(bus.RDATA),   64'h4142_4344);
      check("r_hold_arready", 64'(bus.ARREADY), 64'd0);
      @(posedge clk); #1;
    end
    bus.RREADY = 1'b1;
    drain(20);

    // Write commit and read sample on the same edge: old value returned
    exp_b.push_back(2'b00);
    exp_r.push_back({2'b00, 32'h4142_4344});
    bus.AWADDR = 12'h004; bus.AWVALID = 1'b1;
    bus.WDATA = 32'hDEAD_BEEF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(negedge clk);
    check("coll_awready", 64'(bus.AWREADY), 64'd1);
    check("coll_wready",  64'(bus.WREADY),  64'd1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.ARADDR = 12'h004; bus.ARVALID = 1'b1;
    @(negedge clk);
    check("coll_arready", 64'(bus.ARREADY), 64'd1);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    drain(20);
    check("coll_vram1_new", 64'(vram_w[1]), 64'hDEAD_BEEF);
    exp_r.push_back({2'b00, 32'hDEAD_BEEF});
    issue_read(12'h004);
    drain(20);

`ifdef VRAM_CLEAR_EN
    for (int i = 0; i < 600; i++) begin
      exp_b.push_back(2'b00);
      issue_write(12'(i * 4), 32'h1234_5678, 4'hF, 0, 0, 20, cyc);
      drain(20);
    end
    bad = 0;
    for (int i = 0; i < 600; i++) if (vram_w[i] !== 32'h1234_5678) bad++;
    check("fill_bad_words", 64'(bad), 64'd0);

    exp_b.push_back(2'b00);
    issue_write(12'h960, 32'h8000_0000, 4'hF, 0, 0, 20, cyc);
    drain(20);
    @(negedge clk);
    check("clr_busy_bit",  64'(vram_w[600][31]), 64'd1);
    check("clr_awready",   64'(bus.AWREADY),     64'd0);
    check("clr_wready",    64'(bus.WREADY),      64'd0);
    @(posedge clk); #1;
    exp_r.push_back({2'b00, 32'h1234_5678});
    issue_read(12'h95C);
    drain(20);
    exp_r.push_back({2'b00, 32'h8000_0000});
    issue_read(12'h960);
    drain(20);
    exp_r.push_back({2'b00, 32'h0});
    issue_read(12'h000);
    drain(20);

    exp_b.push_back(2'b00);
    issue_write(12'h010, 32'hAAAA_5555, 4'hF, 0, 0, 1000, cyc);
    check("clr_write_stalled", 64'(cyc > 500), 64'd1);
    drain(20);
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      if (vram_w[i] !== ((i == 4) ? 32'hAAAA_5555 : 32'h0)) bad++;
    end
    check("clr_bad_words",     64'(bad),         64'd0);
    check("clr_palette_after", 64'(vram_w[600]), 64'd0);
    exp_r.push_back({2'b00, 32'h0});
    issue_read(12'h960);
    drain(20);
`else
    exp_b.push_back(2'b00);
    issue_write(12'h960, 32'h8000_0000, 4'hF, 0, 0, 20, cyc);
    drain(20);
    @(negedge clk);
    check("plain_awready_after", 64'(bus.AWREADY), 64'd1);
    check("plain_vram0_kept",    64'(vram_w[0]),   64'd0);
    check("plain_vram1_kept",    64'(vram_w[1]),   64'hDEAD_BEEF);
    @(posedge clk); #1;
    exp_r.push_back({2'b00, 32'h8000_0000});
    issue_read(12'h960);
    drain(20);
`endif

    check("b_queue_empty", 64'(exp_b.size()), 64'd0);
    check("r_queue_empty", 64'(exp_r.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
